keypad_entry: RTL and testbench

Front-end for the digital safe lock. Scans a 4x4 active-low matrix keypad, debounces presses, and encodes them into the 4-bit `key` code and the `unlock_button` strobe that the lock consumes. The lock samples `key` on the rising edge of `unlock_button`. This block is therefore the producer side of that interface: it holds `key` stable and emits a clean single-cycle strobe on the Enter key. Entry is suppressed while the lock reports lockout.

---
 rtl/keypad_entry_if.sv | 28 ++
 rtl/keypad_entry.sv | 168 ++++++++++++++++
 tb/tb_keypad_entry.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/keypad_entry_if.sv
// Keypad-entry signal bundle: matrix scan lines plus the key/strobe interface
// consumed by the lock. "master" is the keypad_entry side.
interface keypad_entry_if;
    logic [3:0] row;
    logic [3:0] col;
    logic       lock_active;
    logic [3:0] key;
    logic       key_valid;
    logic       unlock_button;

    modport master (
        input  row,
        input  lock_active,
        output col,
        output key,
        output key_valid,
        output unlock_button
    );

    modport slave (
        output row,
        output lock_active,
        input  col,
        input  key,
        input  key_valid,
        input  unlock_button
    );
endinterface

// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner with press/release debounce. Encodes digits onto
// key/key_valid, Enter onto unlock_button, '*' clears key. Suppressed in lockout.
module keypad_entry #(
    parameter int unsigned SCAN_DIV     = 16,
    parameter int unsigned DEBOUNCE_CNT = 1000
) (
    input  logic           clk,
    input  logic           rst,
    keypad_entry_if.master kp
);

    localparam int unsigned DwellW = $clog2(SCAN_DIV);
    localparam int unsigned DebW   = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DIV - 1);
    localparam logic [DebW-1:0]   DebTarget = DebW'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {StScan, StDebPress, StHeld, StDebRelease} state_e;

    state_e            state_q, state_d;
    logic [3:0]        row_meta_q, row_s_q;
    logic [1:0]        col_idx_q, col_idx_d;
    logic [DwellW-1:0] dwell_q, dwell_d;
    logic [DebW-1:0]   deb_q, deb_d;
    logic [3:0]        cap_row_q, cap_row_d;
    logic [3:0]        cap_key_q, cap_key_d;   // {row index, column index}
    logic [3:0]        col_q, col_d;
    logic [3:0]        key_q, key_d;
    logic              key_valid_q, key_valid_d;
    logic              unlock_q, unlock_d;

    logic              row_one_low;
    logic [1:0]        row_idx;
    logic [DebW-1:0]   deb_inc;
    logic [1:0]        col_adv;
    logic [3:0]        digit;

    // Decode the synchronized row pattern: exactly one low bit is a valid press.
    always_comb begin
        row_one_low = 1'b1;
        row_idx     = 2'd0;
        unique case (row_s_q)
            4'b1110: row_idx = 2'd0;
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_one_low = 1'b0;
        endcase
    end

    assign deb_inc = (deb_q == DebTarget) ? deb_q : deb_q + 1'b1;
    assign col_adv = col_idx_q + 2'd1;
    // Rows 0..2, columns 0..2 map to digits 1..9 in reading order.
    assign digit   = {2'b00, cap_key_q[3:2]} * 4'd3 + {2'b00, cap_key_q[1:0]} + 4'd1;

    // Scan/debounce FSM next state and the registered key action.
    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        dwell_d     = dwell_q;
        deb_d       = deb_q;
        cap_row_d   = cap_row_q;
        cap_key_d   = cap_key_q;
        key_d       = key_q;
        key_valid_d = 1'b0;
        unlock_d    = 1'b0;
        unique case (state_q)
            StScan: begin
                if (dwell_q == DwellLast) begin
                    dwell_d = '0;
                    if (row_one_low) begin
                        // Column stays driven while the press is debounced.
                        cap_row_d = row_s_q;
                        cap_key_d = {row_idx, col_idx_q};
                        deb_d     = '0;
                        state_d   = StDebPress;
                    end else begin
                        col_idx_d = col_adv;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            StDebPress: begin
                if (row_s_q == cap_row_q) begin
                    deb_d = deb_inc;
                    if (deb_inc == DebTarget) begin
                        state_d = StHeld;
                        // Lockout discards the action but still enters HELD.
                        if (!kp.lock_active && cap_key_q[1:0] != 2'd3) begin
                            if (cap_key_q[3:2] != 2'd3) begin
                                key_d       = digit;
                                key_valid_d = 1'b1;
                            end else if (cap_key_q[1:0] == 2'd0) begin
                                key_d = 4'd0;
                            end else if (cap_key_q[1:0] == 2'd1) begin
                                key_d       = 4'd0;
                                key_valid_d = 1'b1;
                            end else begin
                                unlock_d = 1'b1;
                            end
                        end
                    end
                end else begin
                    state_d   = StScan;
                    col_idx_d = col_adv;
                    dwell_d   = '0;
                end
            end
            StHeld: begin
                if (row_s_q == 4'hF) begin
                    deb_d   = '0;
                    state_d = StDebRelease;
                end
            end
            StDebRelease: begin
                if (row_s_q == 4'hF) begin
                    deb_d = deb_inc;
                    if (deb_inc == DebTarget) begin
                        state_d   = StScan;
                        col_idx_d = col_adv;
                        dwell_d   = '0;
                    end
                end else begin
                    state_d = StHeld;
                end
            end
            default: state_d = StScan;
        endcase
        col_d = ~(4'b0001 << col_idx_d);
    end

    // All state, the row synchronizer and the registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StScan;
            row_meta_q  <= 4'hF;
            row_s_q     <= 4'hF;
            col_idx_q   <= 2'd0;
            dwell_q     <= '0;
            deb_q       <= '0;
            cap_row_q   <= 4'hF;
            cap_key_q   <= 4'd0;
            col_q       <= 4'b1110;
            key_q       <= 4'd0;
            key_valid_q <= 1'b0;
            unlock_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_meta_q  <= kp.row;
            row_s_q     <= row_meta_q;
            col_idx_q   <= col_idx_d;
            dwell_q     <= dwell_d;
            deb_q       <= deb_d;
            cap_row_q   <= cap_row_d;
            cap_key_q   <= cap_key_d;
            col_q       <= col_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            unlock_q    <= unlock_d;
        end
    end

    assign kp.col           = col_q;
    assign kp.key           = key_q;
    assign kp.key_valid     = key_valid_q;
    assign kp.unlock_button = unlock_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: keypad matrix model, table-driven key presses,
// pulse scoreboard, and hand-written reset/bounce/lockout/multi-key sequences.
module tb_keypad_entry;

    localparam int KNone  = 0;
    localparam int KDigit = 1;
    localparam int KEnter = 2;

    typedef struct {
        int         kind;
        logic [3:0] key;
    } exp_t;

    typedef struct {
        int         r;
        int         c;
        logic       lk;
        int         kind;
        logic [3:0] key_after;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [3:0][3:0] pressed;   // pressed[row][col]
    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    vec_t vecs[10];
    logic [3:0] model_key;

    keypad_entry_if kp ();

    keypad_entry #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kp)
    );

    always #5 clk = ~clk;

    // Matrix model: a pressed switch pulls its row low while its column is driven.
    always_comb begin
        kp.row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r][c] && !kp.col[c]) kp.row[r] = 1'b0;
    end

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Scoreboard: every output pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && (kp.key_valid || kp.unlock_button)) begin
            exp_t e;
            chk("pulse_exclusive", int'(kp.key_valid && kp.unlock_button), 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got kv=%0b ub=%0b key=%0d expected no pulse",
                         kp.key_valid, kp.unlock_button, kp.key);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_kind", kp.key_valid ? KDigit : KEnter, e.kind);
                chk("pulse_key", int'(kp.key), int'(e.key));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input int kind, input logic [3:0] key);
        exp_t e;
        e.kind = kind;
        e.key  = key;
        exp_q.push_back(e);
    endtask

    task automatic check_outputs_reset(input string tag);
        chk({tag, "_col"}, int'(kp.col), 4'b1110);
        chk({tag, "_key"}, int'(kp.key), 0);
        chk({tag, "_kv"}, int'(kp.key_valid), 0);
        chk({tag, "_ub"}, int'(kp.unlock_button), 0);
    endtask

    initial begin
        logic [3:0] seen;
        logic [3:0] col_exp;

        vecs[0] = '{1, 1, 1'b0, KDigit, 4'd5};
        vecs[1] = '{2, 0, 1'b0, KDigit, 4'd7};
        vecs[2] = '{3, 2, 1'b0, KEnter, 4'd7};
        vecs[3] = '{3, 0, 1'b0, KNone,  4'd0};
        vecs[4] = '{0, 3, 1'b0, KNone,  4'd0};
        vecs[5] = '{0, 2, 1'b0, KDigit, 4'd3};
        vecs[6] = '{2, 2, 1'b1, KNone,  4'd3};
        vecs[7] = '{3, 0, 1'b1, KNone,  4'd3};
        vecs[8] = '{3, 1, 1'b0, KDigit, 4'd0};
        vecs[9] = '{3, 2, 1'b1, KNone,  4'd0};

        rst = 1'b1;
        pressed = '0;
        kp.lock_active = 1'b0;
        model_key = 4'd0;
        #3;
        check_outputs_reset("init");
        cycles(2);
        rst = 1'b0;
        cycles(3);

        // Table-driven single-key presses.
        for (int i = 0; i < 10; i++) begin
            kp.lock_active = vecs[i].lk;
            if (vecs[i].kind != KNone) push_exp(vecs[i].kind, vecs[i].key_after);
            pressed[vecs[i].r][vecs[i].c] = 1'b1;
            cycles(40);
            col_exp = ~(4'b0001 << vecs[i].c);
            chk("held_col", int'(kp.col), int'(col_exp));
            pressed = '0;
            cycles(30);
            kp.lock_active = 1'b0;
            chk("pending_pulse", exp_q.size(), 0);
            chk("key_after", int'(kp.key), int'(vecs[i].key_after));
            model_key = vecs[i].key_after;
        end

        // Bounce on "3": toggling faster than the debounce window must not fire.
        for (int k = 0; k < 10; k++) begin
            pressed[0][2] = ~pressed[0][2];
            cycles(3);
        end
        pressed[0][2] = 1'b1;
        push_exp(KDigit, 4'd3);
        cycles(40);
        chk("bounce_col", int'(kp.col), 4'b1011);
        pressed = '0;
        cycles(30);
        chk("bounce_pending", exp_q.size(), 0);
        chk("bounce_key", int'(kp.key), 3);
        model_key = 4'd3;

        // Two rows in one column: ignored, scan keeps rotating.
        pressed[0][1] = 1'b1;
        pressed[1][1] = 1'b1;
        seen = 4'h0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            seen = seen | ~kp.col;
        end
        chk("multi_rotate", int'(seen), 4'hF);
        pressed = '0;
        cycles(20);
        chk("multi_key", int'(kp.key), int'(model_key));

        // Press held across the end of lockout must not fire.
        kp.lock_active = 1'b1;
        pressed[2][2] = 1'b1;
        cycles(30);
        kp.lock_active = 1'b0;
        cycles(30);
        chk("lock_held_col", int'(kp.col), 4'b1011);
        pressed = '0;
        cycles(30);
        chk("lock_held_key", int'(kp.key), int'(model_key));

        // Asynchronous reset mid-operation, away from any clock edge.
        push_exp(KDigit, 4'd5);
        pressed[1][1] = 1'b1;
        cycles(40);
        chk("pre_reset_pending", exp_q.size(), 0);
        chk("pre_reset_key", int'(kp.key), 5);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_outputs_reset("async");
        pressed = '0;
        model_key = 4'd0;
        cycles(2);
        rst = 1'b0;
        cycles(20);

        // Reset during DEB_PRESS: key "1" in column 0 is captured right after reset.
        rst = 1'b1;
        pressed[0][0] = 1'b1;
        cycles(2);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_outputs_reset("debrst");
        cycles(2);
        rst = 1'b0;
        push_exp(KDigit, 4'd1);
        cycles(40);
        chk("debrst_pending", exp_q.size(), 0);
        chk("debrst_key", int'(kp.key), 1);
        pressed = '0;
        cycles(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
